// File: rtl/uart_tx_framer.sv
// uart_tx_framer: pulls words from a TX FIFO read port and serialises them as
// UART frames (start, LSB-first data, optional parity, one stop bit).
// Back-to-back words are sent with no idle gap between frames.
module uart_tx_framer #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_rinc,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pen_q, pen_d;
   logic                  ptyp_q, ptyp_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  pop;
   logic                  bit_end;

   // The current serial bit has been held for its full CLKS_PER_BIT cycles.
   assign bit_end = (cnt_q == CNT_LAST);

   // A pop never escapes while reset is asserted, even if the FSM would take one.
   assign fifo_rinc = pop & ~rst;

   assign tx_out = tx_q;
   assign busy   = busy_q;

   // Next-state logic: bit timing, bit index, frame capture on pop, and the
   // registered line/busy values derived from where the FSM is going next.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      pen_d   = pen_q;
      ptyp_d  = ptyp_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      busy_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!fifo_empty) begin
               pop = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = pen_q ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next frame when a word is waiting.
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Word and framing options are frozen at the pop; nothing later reaches them.
      if (pop) begin
         data_d  = fifo_rdata;
         pen_d   = par_en;
         ptyp_d  = par_typ;
         cnt_d   = '0;
         idx_d   = '0;
         state_d = START;
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[idx_d];
         PARITY:  tx_d = (^data_d) ^ ptyp_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset to an idle, high line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         pen_q   <= 1'b0;
         ptyp_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         pen_q   <= pen_d;
         ptyp_q  <= ptyp_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: a FIFO model feeds the DUT and records
// each popped word with its framing options; a negedge monitor rebuilds the
// expected line waveform from UART framing rules and compares every cycle.
module tb_uart_tx_framer;
   localparam int DW = 8;
   localparam int C  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_rdata = '0;
   logic          fifo_rinc;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic          tx_out;
   logic          busy;

   uart_tx_framer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rinc  (fifo_rinc),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          pen;
      logic          ptyp;
   } frame_t;

   frame_t        sb[$];
   logic [DW-1:0] fq[$];

   int checks = 0;
   int errors = 0;

   // control from the main sequence
   logic mon_en = 1'b0;
   logic abort_ok = 1'b0;
   logic pen_cfg = 1'b0;
   logic ptyp_cfg = 1'b0;
   logic tog = 1'b0;
   logic rand_par = 1'b0;

   // monitor-owned
   logic   rinc_n = 1'b0;
   int     busy_cycles = 0;
   int     busy_rises = 0;
   logic   busy_prev = 1'b0;
   int     frames = 0;
   int     aborts = 0;
   int     last_rinc_k = -1;
   logic   line_w [0:11];
   logic   last_line [0:11];
   logic   in_frame = 1'b0;
   frame_t cur;
   int     k = 0;
   int     ferr = 0;
   int     fk = 0;
   logic   fa = 1'b0;
   logic   fe = 1'b0;

   // FIFO-model owned
   int pops = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int frame_len(input frame_t f);
      return (DW + 2 + (f.pen ? 1 : 0)) * C;
   endfunction

   // Expected line level at cycle kk of a frame, straight from UART framing rules.
   function automatic logic exp_bit(input frame_t f, input int kk);
      int b;
      b = kk / C;
      if (b == 0) return 1'b0;
      if (b <= DW) return f.data[b-1];
      if (b == DW + 1 && f.pen) return 1'(($countones(f.data) % 2) == 1) ^ f.ptyp;
      return 1'b1;
   endfunction

   // FIFO model: applies pops seen last cycle and drives read-side inputs.
   initial begin
      logic [DW-1:0] w;
      forever begin
         @(posedge clk);
         #1;
         if (rinc_n && fq.size() > 0) begin
            w = fq.pop_front();
            sb.push_back('{data: w, pen: par_en, ptyp: par_typ});
            pops++;
         end
         if (rand_par) begin
            if ($urandom_range(0, 3) == 0) par_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) par_typ = 1'($urandom_range(0, 1));
         end else if (tog && fq.size() == 0) begin
            par_en  = ~par_en;
            par_typ = ~par_typ;
         end else begin
            par_en  = pen_cfg;
            par_typ = ptyp_cfg;
         end
         fifo_empty = (fq.size() == 0);
         if (fq.size() > 0) fifo_rdata = fq[0];
         else if (tog) fifo_rdata = DW'($urandom);
      end
   end

   // Monitor: pops the scoreboard at each frame start and checks every line cycle.
   always @(negedge clk) begin
      rinc_n = (fifo_rinc === 1'b1);
      if (mon_en) begin
         if (rst) check("rinc_in_rst", 32'(fifo_rinc), 0);
         else if (fifo_rinc === 1'b1) check("rinc_when_empty", 32'(fifo_empty), 0);
         if (busy === 1'b1) busy_cycles++;
         if (busy === 1'b1 && !busy_prev) busy_rises++;
         busy_prev = (busy === 1'b1);

         if (!in_frame && busy === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_frame", 1, 0);
            end else begin
               cur = sb.pop_front();
               in_frame = 1'b1;
               k = 0;
               ferr = 0;
            end
         end else if (!in_frame) begin
            check("idle_tx", 32'(tx_out), 1);
         end

         if (in_frame) begin
            if (busy !== 1'b1) begin
               check("abort_allowed", 32'(abort_ok), 1);
               check("abort_tx", 32'(tx_out), 1);
               $display("frame data=%02h aborted at cycle %0d", cur.data, k);
               aborts++;
               in_frame = 1'b0;
            end else begin
               if (tx_out !== exp_bit(cur, k)) begin
                  ferr++;
                  if (ferr == 1) begin
                     fk = k;
                     fa = tx_out;
                     fe = exp_bit(cur, k);
                  end
               end
               if (fifo_rinc === 1'b1) last_rinc_k = k;
               if (k % C == 1) line_w[k/C] = tx_out;
               k++;
               if (k == frame_len(cur)) begin
                  checks++;
                  if (ferr != 0) begin
                     errors++;
                     $display("FAIL frame data=%02h pen=%0d ptyp=%0d cycle %0d tx=%0b expected=%0b (%0d bad cycles)",
                              cur.data, cur.pen, cur.ptyp, fk, fa, fe, ferr);
                  end else begin
                     $display("frame data=%02h pen=%0d ptyp=%0d len=%0d ok", cur.data, cur.pen, cur.ptyp, k);
                  end
                  frames++;
                  last_line = line_w;
                  in_frame = 1'b0;
               end
            end
         end
      end
   end

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      @(negedge clk);
      while (!(fq.size() == 0 && busy === 1'b0 && !in_frame && fifo_rinc === 1'b0) && n < max) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(n >= max), 0);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, r0, p0, f0, a0, bad, n;
      int exp_a5 [0:9];
      exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(tx_out), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_rinc", 32'(fifo_rinc), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;

      // empty FIFO for 100 cycles
      p0 = pops;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rinc !== 1'b0) bad++;
      end
      check("idle_100_bad", 32'(bad), 0);
      check("idle_100_pops", 32'(pops - p0), 0);

      // single word 0xA5, no parity
      pen_cfg = 1'b0; ptyp_cfg = 1'b0;
      b0 = busy_cycles; r0 = busy_rises; p0 = pops;
      fq.push_back(8'hA5);
      wait_idle(500);
      check("a5_busy_cycles", 32'(busy_cycles - b0), 40);
      check("a5_pops", 32'(pops - p0), 1);
      for (int i = 0; i < 10; i++) check($sformatf("a5_bit%0d", i), 32'(last_line[i]), 32'(exp_a5[i]));

      // 0x07 with even then odd parity
      pen_cfg = 1'b1; ptyp_cfg = 1'b0;
      b0 = busy_cycles;
      fq.push_back(8'h07);
      wait_idle(500);
      check("p07_even_len", 32'(busy_cycles - b0), 44);
      check("p07_even_par", 32'(last_line[9]), 1);
      check("p07_even_stop", 32'(last_line[10]), 1);
      ptyp_cfg = 1'b1;
      b0 = busy_cycles;
      fq.push_back(8'h07);
      wait_idle(500);
      check("p07_odd_len", 32'(busy_cycles - b0), 44);
      check("p07_odd_par", 32'(last_line[9]), 0);

      // back-to-back 0x55, 0x0F
      pen_cfg = 1'b0; ptyp_cfg = 1'b0;
      b0 = busy_cycles; r0 = busy_rises; p0 = pops;
      fq.push_back(8'h55);
      fq.push_back(8'h0F);
      wait_idle(500);
      check("b2b_busy_cycles", 32'(busy_cycles - b0), 80);
      check("b2b_busy_rises", 32'(busy_rises - r0), 1);
      check("b2b_pops", 32'(pops - p0), 2);
      check("b2b_rinc_cycle", 32'(last_rinc_k), 39);

      // reset held while a word waits: no pop under reset
      p0 = pops;
      @(posedge clk);
      #1 rst = 1'b1;
      fq.push_back(8'h3C);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle(500);
      check("rsthold_pops", 32'(pops - p0), 1);

      // reset pulse during data bit 3, then the next word goes out intact
      p0 = pops; f0 = frames; a0 = aborts;
      fq.push_back(8'hC3);
      fq.push_back(8'h96);
      n = 0;
      @(negedge clk);
      while (busy !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_start_timeout", 32'(n >= 100), 0);
      repeat (17) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      abort_ok = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_tx_after", 32'(tx_out), 1);
      check("abort_busy_after", 32'(busy), 0);
      wait_idle(500);
      abort_ok = 1'b0;
      check("abort_count", 32'(aborts - a0), 1);
      check("abort_pops", 32'(pops - p0), 2);
      check("abort_next_frames", 32'(frames - f0), 1);

      // data and parity type toggling after the pop
      pen_cfg = 1'b1; ptyp_cfg = 1'($urandom_range(0, 1));
      tog = 1'b1;
      f0 = frames;
      fq.push_back(DW'($urandom));
      wait_idle(500);
      tog = 1'b0;
      check("tog_frames", 32'(frames - f0), 1);

      // randomized traffic with randomly moving parity options
      rand_par = 1'b1;
      p0 = pops; f0 = frames;
      for (int i = 0; i < 30; i++) begin
         fq.push_back(DW'($urandom));
         if ($urandom_range(0, 2) == 0) fq.push_back(DW'($urandom));
         repeat ($urandom_range(0, 50)) @(negedge clk);
      end
      rand_par = 1'b0;
      wait_idle(5000);
      check("rand_frames_vs_pops", 32'(frames - f0), 32'(pops - p0));

      check("sb_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
